// File: rtl/nxt_block_pkg.sv
// Shared constants, FSM state type and pick helpers for the next-block generator.
// The bag helper is only referenced when NXT_BLOCK_BAG_EN is defined.
package nxt_block_pkg;

  localparam int NumShapes = 7;

  localparam logic [4:0] BlkI    = 5'b10000;
  localparam logic [4:0] BlkO    = 5'b10001;
  localparam logic [4:0] BlkT    = 5'b10010;
  localparam logic [4:0] BlkS    = 5'b10011;
  localparam logic [4:0] BlkZ    = 5'b10100;
  localparam logic [4:0] BlkJ    = 5'b10101;
  localparam logic [4:0] BlkL    = 5'b10110;
  localparam logic [4:0] BlkNone = 5'b00000;

  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, shifting left: taps on bits 15, 13, 12, 10
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StFillCur,
    StFillNxt,
    StReady,
    StRefill
  } state_e;

  function automatic logic [4:0] idx_to_code(input logic [2:0] idx);
    logic [4:0] code;
    case (idx)
      3'd0:    code = BlkI;
      3'd1:    code = BlkO;
      3'd2:    code = BlkT;
      3'd3:    code = BlkS;
      3'd4:    code = BlkZ;
      3'd5:    code = BlkJ;
      3'd6:    code = BlkL;
      default: code = BlkNone;
    endcase
    return code;
  endfunction

  // First index not yet used in the bag, scanning cyclically upward from cand.
  function automatic logic [2:0] bag_pick(input logic [2:0] cand, input logic [6:0] used);
    logic [2:0] idx;
    logic [3:0] sum;
    logic       found;
    idx   = cand;
    found = 1'b0;
    for (int k = 0; k < NumShapes; k++) begin
      sum = {1'b0, cand} + 4'(k);
      if (sum >= 4'(NumShapes)) begin
        sum = sum - 4'(NumShapes);
      end
      if (!found && !used[sum[2:0]]) begin
        idx   = sum[2:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
// SEED must be nonzero or the register locks at zero.
module lfsr16
  import nxt_block_pkg::*;
#(
  parameter logic [15:0] SEED = LfsrSeedDefault
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = ^(state & LfsrTaps);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/nxt_block_gen.sv
// Tetromino sequencer: current piece for game logic, next piece for the preview stage.
// Define NXT_BLOCK_BAG_EN for the 7-bag selector; otherwise the pick is lfsr[2:0] with 7 -> 0.
module nxt_block_gen
  import nxt_block_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LfsrSeedDefault
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       req,
  output logic       ready,
  output logic       cur_valid,
  output logic [4:0] cur_block,
  output logic [4:0] buf_block
);

  logic [15:0] lfsr;
  logic [2:0]  cand;
  logic [2:0]  pick_idx;
  logic [4:0]  pick_code;
  state_e      state_q;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .pclk (pclk),
    .rst_n(rst_n),
    .state(lfsr)
  );

  assign cand = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

`ifdef NXT_BLOCK_BAG_EN
  logic [6:0] used_q;
  logic [6:0] used_d;

  assign pick_idx = bag_pick(cand, used_q);

  // Completing the bag clears the mask so the next pick opens a fresh bag.
  always_comb begin
    used_d = used_q | (7'd1 << pick_idx);
    if (used_d == 7'h7F) begin
      used_d = '0;
    end
  end
`else
  assign pick_idx = cand;
`endif

  assign pick_code = idx_to_code(pick_idx);

  // Only the low bits feed the pick; the rest of the state just keeps the sequence long.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr[15:3];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ready     <= 1'b0;
      cur_valid <= 1'b0;
      cur_block <= BlkNone;
      buf_block <= BlkNone;
`ifdef NXT_BLOCK_BAG_EN
      used_q    <= '0;
`endif
    end else if (stop) begin
      state_q   <= StIdle;
      ready     <= 1'b0;
      cur_valid <= 1'b0;
      cur_block <= BlkNone;
      buf_block <= BlkNone;
`ifdef NXT_BLOCK_BAG_EN
      used_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFillCur;
          end
        end
        StFillCur: begin
          cur_block <= pick_code;
`ifdef NXT_BLOCK_BAG_EN
          used_q    <= used_d;
`endif
          state_q   <= StFillNxt;
        end
        StFillNxt: begin
          buf_block <= pick_code;
          cur_valid <= 1'b1;
          ready     <= 1'b1;
`ifdef NXT_BLOCK_BAG_EN
          used_q    <= used_d;
`endif
          state_q   <= StReady;
        end
        StReady: begin
          if (req) begin
            cur_block <= buf_block;
            ready     <= 1'b0;
            state_q   <= StRefill;
          end
        end
        StRefill: begin
          buf_block <= pick_code;
          ready     <= 1'b1;
`ifdef NXT_BLOCK_BAG_EN
          used_q    <= used_d;
`endif
          state_q   <= StReady;
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nxt_block_gen.sv
// Scoreboard bench for nxt_block_gen: a bench-side LFSR and pick model predicts every piece.
module tb_nxt_block_gen;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       req;
  logic       ready;
  logic       cur_valid;
  logic [4:0] cur_block;
  logic [4:0] buf_block;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_lfsr;
  logic [6:0]  m_used;
  logic [4:0]  exp_cur;
  logic [4:0]  exp_buf;
  logic [4:0]  exp_q[$];
  logic [6:0]  seen;

  nxt_block_gen #(
    .LFSR_SEED(16'hACE1)
  ) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .req      (req),
    .ready    (ready),
    .cur_valid(cur_valid),
    .cur_block(cur_block),
    .buf_block(buf_block)
  );

  always #5 pclk = ~pclk;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Mirrors the DUT's LFSR register: between edges it holds the value the next pick will use.
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  function automatic logic [4:0] model_pick(input logic [15:0] s);
    int c;
    int idx;
    c = int'(s[2:0]);
    if (c == 7) c = 0;
    idx = c;
`ifdef NXT_BLOCK_BAG_EN
    for (int k = 0; k < 7; k++) begin
      if (!m_used[(c + k) % 7]) begin
        idx = (c + k) % 7;
        break;
      end
    end
    m_used[idx] = 1'b1;
    if (m_used == 7'h7F) m_used = '0;
`endif
    return 5'(16 + idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cur"}, cur_block, 5'b00000);
    check({tag, "_buf"}, buf_block, 5'b00000);
    check({tag, "_valid"}, cur_valid, 1'b0);
    check({tag, "_ready"}, ready, 1'b0);
  endtask

  task automatic note(input logic [4:0] code);
    seen = seen | (7'd1 << code[2:0]);
  endtask

  task automatic do_start();
    logic [15:0] s;
    s = step(m_lfsr);
    exp_q.push_back(model_pick(s));
    exp_q.push_back(model_pick(step(s)));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fill_cur_pending", cur_block, 5'b00000);
    check("fill_cur_ready", ready, 1'b0);
    tick();
    exp_cur = exp_q.pop_front();
    check("fill_cur", cur_block, exp_cur);
    check("fill_cur_valid", cur_valid, 1'b0);
    check("fill_cur_ready2", ready, 1'b0);
    tick();
    exp_buf = exp_q.pop_front();
    check("fill_nxt", buf_block, exp_buf);
    check("fill_nxt_cur", cur_block, exp_cur);
    check("fill_nxt_valid", cur_valid, 1'b1);
    check("fill_nxt_ready", ready, 1'b1);
  endtask

  task automatic do_req();
    check("req_ready", ready, 1'b1);
    exp_q.push_back(model_pick(step(m_lfsr)));
    req = 1'b1;
    tick();
    req = 1'b0;
    exp_cur = exp_buf;
    check("swap_cur", cur_block, exp_cur);
    check("swap_buf_hold", buf_block, exp_buf);
    check("swap_ready", ready, 1'b0);
    tick();
    exp_buf = exp_q.pop_front();
    check("refill_buf", buf_block, exp_buf);
    check("refill_cur", cur_block, exp_cur);
    check("refill_ready", ready, 1'b1);
    check("refill_range", (buf_block >= 5'b10000) && (buf_block <= 5'b10110), 1'b1);
  endtask

  initial begin
    int swaps;
    start  = 1'b0;
    stop   = 1'b0;
    req    = 1'b0;
    m_used = '0;
    rst_n  = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    check("lfsr_seed", dut.lfsr, 16'hACE1);

    // Two full bags: start + 5 requests, then 7 more requests.
    seen = '0;
    do_start();
    note(cur_block);
    note(buf_block);
    for (int i = 0; i < 5; i++) begin
      do_req();
      note(buf_block);
      tick();
    end
`ifdef NXT_BLOCK_BAG_EN
    check("bag1_perm", seen, 7'h7F);
`endif
    seen = '0;
    for (int i = 0; i < 7; i++) begin
      do_req();
      note(buf_block);
    end
`ifdef NXT_BLOCK_BAG_EN
    check("bag2_perm", seen, 7'h7F);
`endif

    // req held for four cycles: swap, ignored in REFILL, swap, ignored.
    swaps = 0;
    exp_q.push_back(model_pick(step(m_lfsr)));
    exp_q.push_back(model_pick(step(step(step(m_lfsr)))));
    req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ready == 1'b0) swaps++;
      if (c % 2 == 0) begin
        exp_cur = exp_buf;
        check("hold_swap_cur", cur_block, exp_cur);
      end else begin
        exp_buf = exp_q.pop_front();
        check("hold_refill_buf", buf_block, exp_buf);
        check("hold_refill_cur", cur_block, exp_cur);
      end
    end
    req = 1'b0;
    check("hold_swaps", swaps, 2);
    tick();
    check("hold_after_cur", cur_block, exp_cur);
    check("hold_after_buf", buf_block, exp_buf);

    // stop outranks start and req.
    stop  = 1'b1;
    start = 1'b1;
    req   = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check_idle("stop");
    m_used = '0;
    tick();
    req = 1'b0;
    check_idle("req_in_idle");
    tick();

    seen = '0;
    do_start();
    note(cur_block);
    note(buf_block);
    for (int i = 0; i < 5; i++) begin
      do_req();
      note(buf_block);
    end
`ifdef NXT_BLOCK_BAG_EN
    check("bag3_perm", seen, 7'h7F);
`endif

    // Asynchronous reset in the middle of REFILL.
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rst_pre_cur", cur_block, exp_buf);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    rst_n = 1'b1;
    check("lfsr_seed2", dut.lfsr, 16'hACE1);
    m_used = '0;
    exp_q.delete();

    do_start();
    check("cur_range", (cur_block >= 5'b10000) && (cur_block <= 5'b10110), 1'b1);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_req();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nxt_block_gen.md
# nxt_block_gen

Produces the tetromino sequence for the game: the current falling piece for the game logic, and the next piece on `buf_block` for the draw_nxt_block preview stage. A free-running 16-bit LFSR supplies randomness. A 7-bag selector guarantees that each group of seven picks contains every shape exactly once. The block sits in the game-logic domain on `pclk`, between the game controller and the VGA drawing chain.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset. Must be nonzero.
- `pclk  in  1`: pixel clock, the only clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `start  in  1`: one-cycle pulse that begins a game.
- `stop  in  1`: one-cycle pulse that ends a game (game over) and returns the block to IDLE.
- `req  in  1`: request for the next piece, issued when the current piece locks. Honoured only while `ready` is 1.
- `ready  out  1`: 1 only in the READY state.
- `cur_valid  out  1`: `cur_block` holds a valid piece.
- `cur_block  out  5`: code of the current piece.
- `buf_block  out  5`: code of the next piece, sent to draw_nxt_block.

## Operation
- Block codes: I=5'b10000, O=10001, T=10010, S=10011, Z=10100, J=10101, L=10110, NONE=5'b00000.
  - NONE falls in the preview stage's default case, so no preview is drawn.
  - A code is always {2'b10, idx}, where idx is a 3-bit value in 0..6.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every `pclk` cycle in every state, including IDLE. The player's timing of `start` and `req` therefore supplies the entropy.
- Pick, a single combinational result used in the cycle it is registered:
  - cand = lfsr[2:0]; the value 7 maps to 0.
  - idx = the first index not set in the 7-bit `used` mask, scanning cyclically from cand upward (cand, cand+1 … 6, 0 …).
  - After the pick, `used[idx]` is set.
  - If `used` would become 7'h7F, it is cleared to 0 instead, which starts a new bag.
- FSM states:
  - IDLE:
    - Outputs: `cur_valid`=0, `cur_block`=NONE, `buf_block`=NONE, `used`=0.
    - `start` moves to FILL_CUR.
  - FILL_CUR: `cur_block` ← pick; go to FILL_NXT.
  - FILL_NXT: `buf_block` ← pick; `cur_valid` ← 1; go to READY.
  - READY: `ready`=1. On `req`:
    - `cur_block` ← `buf_block`; go to REFILL.
    - `buf_block` is unchanged this cycle.
  - REFILL: `buf_block` ← pick; go to READY.
- Priorities and ignored inputs:
  - `stop` in any state moves to IDLE on the next edge and clears all outputs and `used`. It outranks `start` and `req` in the same cycle.
  - `start` outside IDLE is ignored.
  - `req` outside READY is ignored and dropped, not queued. The controller must hold or re-issue the request.
  - `start` and `req` together in IDLE: only `start` acts.

## Timing
- Reset values: state IDLE, `lfsr`=LFSR_SEED, `used`=0, `cur_valid`=0, `cur_block`=NONE, `buf_block`=NONE, `ready`=0.
- Reset is asynchronous and may be asserted mid-operation. All outputs immediately take their reset values.
- All outputs are registered.
- Start sequence: `start` is sampled in IDLE at edge N.
  - `cur_block` is valid after edge N+1.
  - `buf_block` is valid and `cur_valid`=1 after edge N+2.
  - `ready`=1 after edge N+2.
- Request sequence: `req` is sampled in READY at edge M.
  - The new `cur_block` is visible after edge M.
  - The new `buf_block` is visible after edge M+1.
  - `ready` is 0 for exactly one cycle and is back to 1 after edge M+1.
  - Maximum sustained request rate: one per 2 cycles.
- The preview changes only on a `pclk` edge. Mid-frame changes are acceptable.

## Configuration
- `NXT_BLOCK_BAG_EN`:
  - Defined: the 7-bag selector described above.
  - Undefined: idx = cand. There is no `used` mask, no repeat guarantee, and the logic is smaller.
- FSM, handshake and timing are identical in both builds.

## Structure
- Package `nxt_block_pkg` holds:
  - the seven block codes and NONE,
  - the default seed 16'hACE1,
  - the polynomial tap constants,
  - the FSM state typedef (IDLE, FILL_CUR, FILL_NXT, READY, REFILL).
- Sub-module `lfsr16`: ports `pclk`, `rst_n`, seed parameter, and 16-bit state output.
- Pick logic and FSM live in `nxt_block_gen`.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-REFILL → immediately `buf_block`=5'b00000, `cur_block`=5'b00000, `cur_valid`=0, `ready`=0. After release, the first LFSR value is 16'hACE1.
- Start timing: `start` pulse → `cur_block` ∈ {10000..10110} after 1 edge; `buf_block` ∈ {10000..10110}, `cur_valid`=1 and `ready`=1 after 2 edges.
- Bag completeness (`NXT_BLOCK_BAG_EN` defined):
  - `start`, then 5 `req` pulses spaced 3 cycles apart → the 7 picks (cur, next, 5 refills) are a permutation of 10000..10110.
  - The next 7 picks are again a permutation.
- Handshake:
  - `req` held high for 4 cycles from READY → exactly 2 swaps.
  - `req` in IDLE or REFILL → no change.
  - On each swap, the new `cur_block` equals the prior `buf_block`.
- Stop priority: `stop`, `start` and `req` asserted together in READY → IDLE next cycle, all outputs NONE/0. A later `start` produces a fresh bag.
- Reference-model check (`NXT_BLOCK_BAG_EN` undefined): after 1000 random `req` pulses, the observed sequence matches the bench LFSR model (seed 16'hACE1, cand mapping 7→0), and no codes outside 10000..10110 occur.
